hazard_ctrl: RTL

Pipeline hazard controller for the five-stage CPU. It watches the ID and EX stages and generates the stall, flush and PC-redirect controls that sequence the instruction-fetch stage and the IF/ID and ID/EX pipeline registers. It handles load-use interlocks, taken-branch and jump redirects, and interlocks against a multi-cycle multiply/divide unit. It also keeps saturating event counters for debug readout.

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / PC-redirect sequencing for the five-stage CPU.
// Detects load-use interlocks, taken-branch and jump redirects, and
// interlocks against the multi-cycle multiply/divide unit. Control outputs
// are combinational from the current inputs and registered state; the
// debug event counters are registered and saturate at all-ones.
module hazard_ctrl #(
    parameter int MD_LAT = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_md_start,
    input  logic             id_md_use,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             pc_src,
    output logic             jump_o,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_LU_HOLD = 1'b1
    } state_t;

    localparam logic [7:0]       MD_LAT_C = 8'(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    logic [7:0]         md_cnt_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;

    logic               lu_s;
    logic               md_busy_s;
    logic               md_haz_s;
    logic               lu_take_s;
    logic               md_load_s;
    logic               stall_s;
    logic               stall_d_s;
    logic               flush_d_s;
    logic               flush_e_s;
    logic               pc_src_s;
    logic               jump_s;

    // Hazard detection: a load in EX writing a nonzero register read in ID.
    always_comb begin
        lu_s = 1'b0;
        if (ex_memread && (ex_rt != 5'd0)) begin
            if ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt))) begin
                lu_s = 1'b1;
            end else begin
                lu_s = 1'b0;
            end
        end else begin
            lu_s = 1'b0;
        end
    end

    assign md_busy_s = (md_cnt_r != 8'd0);
    assign md_haz_s  = md_busy_s && (id_md_use || id_md_start);

    // Prioritised control decode: branch > jump > load-use > mult/div.
    always_comb begin
        stall_s   = 1'b0;
        stall_d_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        pc_src_s  = 1'b0;
        jump_s    = 1'b0;
        lu_take_s = 1'b0;
        if (!rst_n) begin
            // Outputs read quiet while reset is held, whatever the inputs.
            stall_s = 1'b0;
        end else if (ex_branch_taken) begin
            // Redirect cancels any interlock; the wrong-path ID instruction
            // is squashed so no stall is needed.
            pc_src_s  = 1'b1;
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (id_jump) begin
            jump_s    = 1'b1;
            flush_d_s = 1'b1;
        end else if (lu_s && (state_r == ST_RUN)) begin
            stall_s   = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
            lu_take_s = 1'b1;
        end else if (md_haz_s) begin
            stall_s   = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // A mult/div is accepted only when it actually leaves ID this cycle.
    always_comb begin
        md_load_s = 1'b0;
        if (id_md_start && !md_busy_s && !stall_s && !flush_d_s && !flush_e_s) begin
            md_load_s = 1'b1;
        end else begin
            md_load_s = 1'b0;
        end
    end

    // Main FSM: LU_HOLD masks load-use detection for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (lu_take_s) begin
                        state_r <= ST_LU_HOLD;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_LU_HOLD: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    // Mult/div latency counter: loads on issue, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_r <= 8'd0;
        end else if (md_load_s) begin
            md_cnt_r <= MD_LAT_C;
        end else if (md_busy_s) begin
            md_cnt_r <= md_cnt_r - 8'd1;
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // Saturating debug counters for stall cycles and PC redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if ((pc_src_s || jump_s) && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall     = stall_s;
    assign stall_d   = stall_d_s;
    assign flush_d   = flush_d_s;
    assign flush_e   = flush_e_s;
    assign pc_src    = pc_src_s;
    assign jump_o    = jump_s;
    assign md_busy   = md_busy_s;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule
